// File: rtl/memory_arbiter_if.sv
// Bundle between the two requesters (instruction fetch, load/store) and the
// single-port memory. The arbiter uses the slave modport; whatever sits on
// the other side (requesters plus memory) uses the master modport.
//
// Signals:
//   fetch_request/fetch_address -> fetch_ready/fetch_value
//   data_request/data_address/data_write_sections/data_write_value
//     -> data_ready/data_read_value
//   memory_address/memory_write_sections/memory_write_value -> memory
//   memory_read_value <- memory (synchronous read, one cycle after address)
interface memory_arbiter_if;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic [31:0] fetch_value;

  logic        data_request;
  logic [31:0] data_address;
  logic [2:0]  data_write_sections;
  logic [31:0] data_write_value;
  logic        data_ready;
  logic [31:0] data_read_value;

  logic [31:0] memory_address;
  logic [2:0]  memory_write_sections;
  logic [31:0] memory_write_value;
  logic [31:0] memory_read_value;

  modport master (
    output fetch_request, fetch_address,
    output data_request, data_address, data_write_sections, data_write_value,
    output memory_read_value,
    input  fetch_ready, fetch_value,
    input  data_ready, data_read_value,
    input  memory_address, memory_write_sections, memory_write_value
  );

  modport slave (
    input  fetch_request, fetch_address,
    input  data_request, data_address, data_write_sections, data_write_value,
    input  memory_read_value,
    output fetch_ready, fetch_value,
    output data_ready, data_read_value,
    output memory_address, memory_write_sections, memory_write_value
  );
endinterface

// File: rtl/memory_arbiter.sv
// Purpose: arbitrates one instruction-fetch and one load/store requester onto
//          a single-port synchronous-read memory, data first with a bounded
//          starvation window for fetch.
// Latency: grant in cycle N (address driven combinationally), ready pulse in
//          cycle N+1; at most one transaction every 2 cycles.
// Backpressure: requesters hold request and operands until their ready pulse;
//          a request seen while busy simply waits for the next IDLE cycle.
//
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - memory_arbiter_if.slave (requester handshakes + memory port)
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            reset,
  memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    BUSY_FETCH = 2'b01,
    BUSY_DATA  = 2'b10
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t      state;
  logic [2:0]  starve_count;
  logic        fetch_ready_q;
  logic        data_ready_q;

  logic        fetch_starved;
  logic        grant_fetch;
  logic        grant_data;

  logic [31:0] mem_address;
  logic [2:0]  mem_write_sections;
  logic [31:0] mem_write_value;

  // Grant is decided in the same cycle the request is seen so the memory
  // sees the address immediately. Reset masks the grant so that the memory
  // port is quiet while reset is held, independent of the request inputs.
  always_comb begin
    fetch_starved = bus.fetch_request && (starve_count == LIMIT);
    grant_fetch   = 1'b0;
    grant_data    = 1'b0;
    if (!reset && state == IDLE) begin
      if (fetch_starved) begin
        grant_fetch = 1'b1;
      end else if (bus.data_request) begin
        grant_data = 1'b1;
      end else if (bus.fetch_request) begin
        grant_fetch = 1'b1;
      end
    end
  end

  // Memory port is driven only in a grant cycle; write enables only ever
  // come from a data grant, so fetches and busy cycles can never write.
  always_comb begin
    mem_address        = 32'd0;
    mem_write_sections = 3'b000;
    mem_write_value    = 32'd0;
    if (grant_data) begin
      mem_address        = bus.data_address;
      mem_write_sections = bus.data_write_sections;
      mem_write_value    = bus.data_write_value;
    end else if (grant_fetch) begin
      mem_address        = bus.fetch_address;
    end
  end

  // Ready pulses are registered copies of the grant: they line up with the
  // cycle in which the synchronous memory returns the read word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      starve_count  <= 3'd0;
      fetch_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
    end else begin
      fetch_ready_q <= grant_fetch;
      data_ready_q  <= grant_data;

      case (state)
        IDLE: begin
          if (grant_data) begin
            state <= BUSY_DATA;
          end else if (grant_fetch) begin
            state <= BUSY_FETCH;
          end
        end
        default: state <= IDLE;
      endcase

      // Count data grants that overtook a waiting fetch; any fetch grant
      // restarts the window.
      if (grant_fetch) begin
        starve_count <= 3'd0;
      end else if (grant_data && bus.fetch_request && starve_count != LIMIT) begin
        starve_count <= starve_count + 3'd1;
      end
    end
  end

  assign bus.fetch_ready           = fetch_ready_q;
  assign bus.data_ready            = data_ready_q;
  assign bus.fetch_value           = bus.memory_read_value;
  assign bus.data_read_value       = bus.memory_read_value;
  assign bus.memory_address        = mem_address;
  assign bus.memory_write_sections = mem_write_sections;
  assign bus.memory_write_value    = mem_write_value;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  localparam int LIMIT = 4;

  logic clk;
  logic reset;

  memory_arbiter_if bus();

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model: which requester (if any) owns the memory this cycle,
  // how many data grants have overtaken a waiting fetch, and what the memory
  // will return for the transaction in flight.
  int          mdl_busy;     // 0 none, 1 fetch in flight, 2 data in flight
  int          mdl_starve;
  logic [31:0] mdl_rd;
  logic        mdl_rd_is_read;
  logic [31:0] mem [logic [31:0]];

  // Values seen at the last sample point, for directed literal checks.
  logic [31:0] obs_addr, obs_wval, obs_fvalue, obs_dvalue;
  logic [2:0]  obs_sections;
  logic        obs_fready, obs_dready;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC3C3_C3C3;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [2:0] sec, input logic [31:0] v);
    logic [31:0] w;
    w = mem_read(a);
    if (sec[0]) w[7:0]   = v[7:0];
    if (sec[1]) w[15:8]  = v[15:8];
    if (sec[2]) w[31:16] = v[31:16];
    mem[a] = w;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: sample and compare at the falling edge, advance the
  // model, then after the rising edge present the memory read word.
  task automatic step();
    int          g;
    logic        e_fr, e_dr;
    logic [31:0] e_addr, e_wval;
    logic [2:0]  e_sec;
    @(negedge clk);
    cyc++;
    g = 0;
    e_fr = 1'b0; e_dr = 1'b0;
    e_addr = 32'd0; e_wval = 32'd0; e_sec = 3'b000;
    if (!reset) begin
      e_fr = (mdl_busy == 1);
      e_dr = (mdl_busy == 2);
      if (mdl_busy == 0) begin
        if (bus.fetch_request && mdl_starve == LIMIT) g = 1;
        else if (bus.data_request) g = 2;
        else if (bus.fetch_request) g = 1;
      end
      if (g == 1) e_addr = bus.fetch_address;
      if (g == 2) begin
        e_addr = bus.data_address;
        e_sec  = bus.data_write_sections;
        e_wval = bus.data_write_value;
      end
    end

    obs_addr     = bus.memory_address;
    obs_sections = bus.memory_write_sections;
    obs_wval     = bus.memory_write_value;
    obs_fready   = bus.fetch_ready;
    obs_dready   = bus.data_ready;
    obs_fvalue   = bus.fetch_value;
    obs_dvalue   = bus.data_read_value;

    chk("fetch_ready", {31'd0, obs_fready}, {31'd0, e_fr});
    chk("data_ready", {31'd0, obs_dready}, {31'd0, e_dr});
    chk("memory_address", obs_addr, e_addr);
    chk("memory_write_sections", {29'd0, obs_sections}, {29'd0, e_sec});
    chk("memory_write_value", obs_wval, e_wval);
    chk("fetch_value_passthru", obs_fvalue, bus.memory_read_value);
    chk("data_read_value_passthru", obs_dvalue, bus.memory_read_value);
    if (e_fr && mdl_rd_is_read) chk("fetch_read_data", obs_fvalue, mdl_rd);
    if (e_dr && mdl_rd_is_read) chk("data_read_data", obs_dvalue, mdl_rd);

    if (reset) begin
      mdl_busy = 0;
      mdl_starve = 0;
      mdl_rd_is_read = 1'b0;
    end else begin
      if (g == 1) mdl_starve = 0;
      else if (g == 2 && bus.fetch_request && mdl_starve < LIMIT) mdl_starve++;
      if (g != 0) begin
        mdl_rd = mem_read(e_addr);
        mdl_rd_is_read = (e_sec == 3'b000);
        if (e_sec != 3'b000) mem_write(e_addr, e_sec, e_wval);
      end
      mdl_busy = g;
    end

    @(posedge clk);
    #1;
    bus.memory_read_value = (mdl_busy != 0) ? mdl_rd : $urandom();
  endtask

  initial begin
    mdl_busy = 0; mdl_starve = 0; mdl_rd = 32'd0; mdl_rd_is_read = 1'b0;
    mem[32'h100] = 32'h0000_0013;

    reset = 1'b1;
    bus.fetch_request = 1'b0; bus.fetch_address = 32'd0;
    bus.data_request = 1'b0; bus.data_address = 32'd0;
    bus.data_write_sections = 3'b000; bus.data_write_value = 32'd0;
    bus.memory_read_value = 32'd0;

    // Reset values must appear without any clock edge.
    #1;
    chk("reset_memory_address", bus.memory_address, 32'd0);
    chk("reset_ready", {30'd0, bus.fetch_ready, bus.data_ready}, 32'd0);
    chk("reset_sections", {29'd0, bus.memory_write_sections}, 32'd0);
    step();
    step();
    reset = 1'b0;

    // Single fetch.
    bus.fetch_request = 1'b1; bus.fetch_address = 32'h100;
    step();
    chk("fetch_grant_addr", obs_addr, 32'h100);
    chk("fetch_grant_no_ready", {31'd0, obs_fready}, 32'd0);
    bus.fetch_request = 1'b0;
    step();
    chk("fetch_ready_pulse", {31'd0, obs_fready}, 32'd1);
    chk("fetch_value_13", obs_fvalue, 32'h13);
    chk("fetch_busy_sections", {29'd0, obs_sections}, 32'd0);

    // Simultaneous fetch and data read: data first.
    bus.fetch_request = 1'b1; bus.fetch_address = 32'h200;
    bus.data_request = 1'b1; bus.data_address = 32'h400;
    step();
    chk("both_first_grant_data", obs_addr, 32'h400);
    step();
    chk("both_data_ready", {31'd0, obs_dready}, 32'd1);
    bus.data_request = 1'b0;
    step();
    chk("both_second_grant_fetch", obs_addr, 32'h200);
    bus.fetch_request = 1'b0;
    step();
    chk("both_fetch_ready", {31'd0, obs_fready}, 32'd1);

    // Starvation window: four data grants then one fetch, repeating.
    bus.fetch_request = 1'b1; bus.fetch_address = 32'h80;
    bus.data_request = 1'b1; bus.data_address = 32'h40;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("starve_grant_%0d", i), obs_addr, (i % 5 == 4) ? 32'h80 : 32'h40);
      step();
    end
    bus.fetch_request = 1'b0; bus.data_request = 1'b0;
    step();

    // Byte store.
    bus.data_request = 1'b1; bus.data_address = 32'h8;
    bus.data_write_value = 32'hAB; bus.data_write_sections = 3'b001;
    step();
    chk("store_sections", {29'd0, obs_sections}, 32'd1);
    chk("store_value", obs_wval, 32'hAB);
    chk("store_addr", obs_addr, 32'h8);
    bus.data_request = 1'b0; bus.data_write_sections = 3'b000;
    step();
    chk("store_ready", {31'd0, obs_dready}, 32'd1);
    chk("store_busy_sections", {29'd0, obs_sections}, 32'd0);
    chk("store_busy_value", obs_wval, 32'd0);

    // Reset during BUSY_DATA abandons the transaction.
    bus.data_request = 1'b1; bus.data_address = 32'h10; bus.data_write_value = 32'd0;
    bus.fetch_request = 1'b1; bus.fetch_address = 32'h300;
    step();
    chk("rst_data_grant", obs_addr, 32'h10);
    chk("rst_busy_ready_before", {31'd0, bus.data_ready}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_ready", {31'd0, bus.data_ready}, 32'd0);
    chk("rst_async_addr", bus.memory_address, 32'd0);
    bus.data_request = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("rst_release_fetch_grant", obs_addr, 32'h300);
    chk("rst_release_no_dready", {31'd0, obs_dready}, 32'd0);
    bus.fetch_request = 1'b0;
    step();
    chk("rst_release_fetch_ready", {31'd0, obs_fready}, 32'd1);
    chk("rst_release_no_dready2", {31'd0, obs_dready}, 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;

      if (bus.fetch_request) begin
        if (bus.fetch_ready) begin
          if ($urandom_range(0, 1) == 0) bus.fetch_address = 32'($urandom_range(0, 255)) << 2;
          else bus.fetch_request = 1'b0;
        end else if ($urandom_range(0, 31) == 0) begin
          bus.fetch_request = 1'b0;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        bus.fetch_request = 1'b1;
        bus.fetch_address = 32'($urandom_range(0, 255)) << 2;
      end

      if (!bus.data_request || bus.data_ready) begin
        if (bus.data_request && $urandom_range(0, 2) == 0) begin
          bus.data_request = 1'b0;
        end else if (bus.data_request || $urandom_range(0, 1) == 0) begin
          bus.data_request = 1'b1;
          bus.data_address = 32'($urandom_range(0, 255)) << 2;
          bus.data_write_value = $urandom();
          bus.data_write_sections = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
        end
      end else if ($urandom_range(0, 31) == 0) begin
        bus.data_request = 1'b0;
      end

      step();
      chk("ready_exclusive", {31'd0, obs_fready & obs_dready}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, range 1..7: maximum consecutive data grants while a fetch request is pending.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 fetch_request  input  1  instruction-fetch requester wants a word read; held high with fetch_address stable until fetch_ready.
REQ-005 fetch_address  input  32  fetch byte address.
REQ-006 fetch_ready  output  1  one-cycle pulse: fetch transaction complete, fetch_value valid.
REQ-007 fetch_value  output  32  read data for fetch; equals memory_read_value.
REQ-008 data_request  input  1  load/store requester wants access; held high with address, sections and write value stable until data_ready.
REQ-009 data_address  input  32  load/store byte address.
REQ-010 data_write_sections  input  3  bit2 high half-word, bit1 low-half high byte, bit0 low byte; 000 means read.
REQ-011 data_write_value  input  32  store data.
REQ-012 data_ready  output  1  one-cycle pulse: data transaction complete, data_read_value valid for reads.
REQ-013 data_read_value  output  32  read data for loads; equals memory_read_value.
REQ-014 memory_address  output  32  address to single-port memory.
REQ-015 memory_write_sections  output  3  write enables to memory, same encoding as REQ-010.
REQ-016 memory_write_value  output  32  write data to memory.
REQ-017 memory_read_value  input  32  synchronous-read memory data, valid the cycle after address presented.

Function
REQ-018 States: IDLE, BUSY_FETCH, BUSY_DATA; 2-bit state register.
REQ-019 IDLE, no request: memory_address=0, memory_write_sections=000, memory_write_value=0; stay IDLE.
REQ-020 IDLE, request(s) present: grant selected combinationally in same cycle; granted requester's address (and, for data, sections/write value) driven to memory; next state BUSY_FETCH or BUSY_DATA.
REQ-021 Grant priority: data over fetch, except when starve_count == STARVE_LIMIT and fetch_request high, then fetch granted.
REQ-022 starve_count (3-bit): increments on each data grant while fetch_request high; cleared on any fetch grant; saturates at STARVE_LIMIT; unchanged otherwise.
REQ-023 BUSY_x: memory_write_sections=000, memory_address=0, memory_write_value=0; matching ready output asserted for exactly this one cycle; next state IDLE.
REQ-024 Latency: grant cycle N -> ready in cycle N+1; maximum throughput one transaction per 2 cycles.
REQ-025 memory_write_sections nonzero only in a data grant cycle; never in BUSY states or for fetch grants.
REQ-026 Ready for a write transaction still pulses; data_read_value don't-care.
REQ-027 Request dropped before ready: no effect on in-flight transaction; ready still pulses, requester ignores it.
REQ-028 Request high in the cycle after ready (IDLE) is a new transaction, arbitrated normally.
REQ-029 fetch_ready and data_ready never high in the same cycle.
REQ-030 fetch_value and data_read_value continuously equal memory_read_value; qualified only by ready.

Reset
REQ-031 reset high: state=IDLE, starve_count=0, fetch_ready=0, data_ready=0, memory_write_sections=000, memory_address=0, memory_write_value=0, immediately without clock.
REQ-032 Reset during BUSY_x abandons transaction; no ready pulse after reset release.
REQ-033 First arbitration occurs on first rising edge with reset low.

Verification
REQ-034 Fetch only, fetch_address=0x100, memory returns 0x00000013 -> memory_address=0x100 cycle N, fetch_ready=1 and fetch_value=0x13 cycle N+1, memory_write_sections=000 throughout.
REQ-035 Simultaneous fetch 0x200 and data read 0x400 -> data granted cycle N (data_ready N+1), fetch granted N+2 (fetch_ready N+3).
REQ-036 Starvation: data_request held continuously, fetch_request high, STARVE_LIMIT=4 -> four data grants, fifth grant to fetch, starve_count back to 0, then data resumes.
REQ-037 Store SB data_address=0x8, data_write_value=0xAB, sections=001 -> memory_write_sections=001, memory_write_value=0xAB only in grant cycle; data_ready next cycle; 000 in BUSY.
REQ-038 Reset asserted in BUSY_DATA cycle -> outputs zero asynchronously, no data_ready; after release a pending fetch is granted on first edge.
